mem_port_arbiter: RTL and testbench

//  Shares one single-port memory bus between instruction fetch (IFU) and data load/store (datapath).

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_watchdog.sv | 31 +++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, owner encoding and a
// counter-width helper used for the streak and watchdog counters.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

   // Bits needed to hold 0..max_val (never less than one bit).
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Watchdog for the arbiter's WAIT phase.
// Ports: clk, rst (sync, active-high), clr (zero the count), en (count one
// cycle), expire_c (count has reached TIMEOUT).
module mem_port_arbiter_watchdog
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire_c
);

   localparam int unsigned CW = cnt_width(TIMEOUT);

   logic [CW-1:0] cnt_q;

   // Count WAIT cycles; hold at TIMEOUT so the counter never wraps.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (en && (cnt_q != CW'(TIMEOUT))) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign expire_c = (cnt_q == CW'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between instruction fetch (if_*) and the
// data path (d_*). One transaction at a time: arbitrate in IDLE, present the
// registered request in REQ until m_gnt, wait for m_rvalid in WAIT and route
// the response to the owner. A watchdog ends hung transactions with an error.
// Ports: clk/rst; fetch requester if_req/if_addr -> if_gnt/if_rvalid/if_rdata/
// if_err; data requester d_req/d_we/d_addr/d_wdata/d_be -> d_gnt/d_rvalid/
// d_rdata/d_err; memory side m_req/m_we/m_addr/m_wdata/m_be <- m_gnt/m_rvalid/
// m_rdata.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned AW          = 32,
   parameter int unsigned DW          = 32,
   parameter int unsigned MAX_DSTREAK = 4,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req,
   input  logic [AW-1:0]   if_addr,
   output logic            if_gnt,
   output logic            if_rvalid,
   output logic [DW-1:0]   if_rdata,
   output logic            if_err,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_be,
   output logic            d_gnt,
   output logic            d_rvalid,
   output logic [DW-1:0]   d_rdata,
   output logic            d_err,
   output logic            m_req,
   output logic            m_we,
   output logic [AW-1:0]   m_addr,
   output logic [DW-1:0]   m_wdata,
   output logic [DW/8-1:0] m_be,
   input  logic            m_gnt,
   input  logic            m_rvalid,
   input  logic [DW-1:0]   m_rdata
);

   localparam int unsigned BW = DW / 8;
   localparam int unsigned SW = cnt_width(MAX_DSTREAK);

   state_t          state_q, state_d;
   owner_t          owner_q;
   logic [SW-1:0]   dstreak_q;
   logic            m_we_q;
   logic [AW-1:0]   m_addr_q;
   logic [DW-1:0]   m_wdata_q;
   logic [BW-1:0]   m_be_q;

   logic            grant_if_c, grant_d_c;
   logic            rsp_valid_c, rsp_err_c;
   logic            wd_clr_c, wd_en_c, wd_expire_c;

   mem_port_arbiter_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .clr      (wd_clr_c),
      .en       (wd_en_c),
      .expire_c (wd_expire_c)
   );

   // Next state, arbitration and response qualification.
   always_comb begin
      state_d     = state_q;
      grant_if_c  = 1'b0;
      grant_d_c   = 1'b0;
      rsp_valid_c = 1'b0;
      rsp_err_c   = 1'b0;
      wd_clr_c    = 1'b0;
      wd_en_c     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // Data has priority until it has starved a waiting fetch long enough.
            if (if_req && (!d_req || (dstreak_q == SW'(MAX_DSTREAK)))) begin
               grant_if_c = 1'b1;
            end else if (d_req) begin
               grant_d_c = 1'b1;
            end
            if (grant_if_c || grant_d_c) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (m_gnt) begin
               state_d  = ST_WAIT;
               wd_clr_c = 1'b1;
            end
         end
         ST_WAIT: begin
            wd_en_c = 1'b1;
            if (m_rvalid) begin
               rsp_valid_c = 1'b1;
               state_d     = ST_IDLE;
            end else if (wd_expire_c) begin
               rsp_valid_c = 1'b1;
               rsp_err_c   = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, captured request, owner and data-streak counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         owner_q   <= OWN_IF;
         dstreak_q <= '0;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         m_be_q    <= '0;
      end else begin
         state_q <= state_d;
         if (grant_if_c) begin
            owner_q   <= OWN_IF;
            m_we_q    <= 1'b0;
            m_addr_q  <= if_addr;
            m_wdata_q <= '0;
            m_be_q    <= '1;
         end else if (grant_d_c) begin
            owner_q   <= OWN_D;
            m_we_q    <= d_we;
            m_addr_q  <= d_addr;
            m_wdata_q <= d_wdata;
            m_be_q    <= d_be;
         end
         if (state_q == ST_IDLE) begin
            if (grant_if_c || !if_req) begin
               dstreak_q <= '0;
            end else if (grant_d_c && (dstreak_q != SW'(MAX_DSTREAK))) begin
               dstreak_q <= dstreak_q + SW'(1);
            end
         end
      end
   end

   // Handshake outputs are forced low during the reset cycle.
   assign if_gnt    = grant_if_c && !rst;
   assign d_gnt     = grant_d_c && !rst;
   assign if_rvalid = rsp_valid_c && (owner_q == OWN_IF) && !rst;
   assign d_rvalid  = rsp_valid_c && (owner_q == OWN_D) && !rst;
   assign if_err    = if_rvalid && rsp_err_c;
   assign d_err     = d_rvalid && rsp_err_c;
   assign if_rdata  = (if_rvalid && !rsp_err_c) ? m_rdata : '0;
   assign d_rdata   = (d_rvalid && !rsp_err_c) ? m_rdata : '0;

   assign m_req   = (state_q == ST_REQ) && !rst;
   assign m_we    = m_we_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign m_be    = m_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MAXD = 4;
   localparam int TMO = 8;

   logic clk = 1'b0;
   logic rst;
   logic if_req, if_gnt, if_rvalid, if_err;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic d_req, d_we, d_gnt, d_rvalid, d_err;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_rdata;
   logic [3:0] d_be;
   logic m_req, m_we, m_gnt, m_rvalid;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata;
   logic [3:0] m_be;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DSTREAK(MAXD), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req = 0; if_addr = '0;
      d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
      m_gnt = 0; m_rvalid = 0; m_rdata = '0;
   endtask

   task automatic do_reset();
      rst = 1; idle_inputs();
      tick(); tick();
      rst = 0;
   endtask

   task automatic test_reset();
      rst = 1; idle_inputs();
      if_req = 1; d_req = 1; m_rvalid = 1; m_gnt = 1;
      tick(); tick();
      @(negedge clk);
      n_cmp++; if (if_gnt !== 1'b0) begin n_bad++; $display("FAIL reset_if_gnt: got %b want 0", if_gnt); end
      n_cmp++; if (d_gnt !== 1'b0) begin n_bad++; $display("FAIL reset_d_gnt: got %b want 0", d_gnt); end
      n_cmp++; if (m_req !== 1'b0) begin n_bad++; $display("FAIL reset_m_req: got %b want 0", m_req); end
      n_cmp++; if ({if_rvalid, d_rvalid, if_err, d_err} !== 4'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0000", {if_rvalid, d_rvalid, if_err, d_err}); end
      n_cmp++; if ({m_we, m_addr, m_wdata, m_be} !== '0) begin n_bad++; $display("FAIL reset_m_regs: got addr %h be %h want 0", m_addr, m_be); end
      tick();
      rst = 0; idle_inputs();
      tick();
   endtask

   task automatic test_single_fetch();
      if_req = 1; if_addr = 32'h100;
      @(negedge clk);
      n_cmp++; if ({if_gnt, d_gnt, m_req} !== 3'b100) begin n_bad++; $display("FAIL fetch_c0: got gnt/dgnt/mreq %b want 100", {if_gnt, d_gnt, m_req}); end
      tick(); if_req = 0; if_addr = 32'hFFFF_0000; m_gnt = 1;
      @(negedge clk);
      n_cmp++; if ({m_req, m_we, m_be, m_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin n_bad++; $display("FAIL fetch_c1: got req %b we %b be %h addr %h want 1 0 f 100", m_req, m_we, m_be, m_addr); end
      tick(); m_gnt = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF;
      @(negedge clk);
      n_cmp++; if ({if_rvalid, if_err, if_rdata} !== {2'b10, 32'hDEADBEEF}) begin n_bad++; $display("FAIL fetch_c2: got rv %b err %b data %h want 1 0 deadbeef", if_rvalid, if_err, if_rdata); end
      n_cmp++; if ({d_rvalid, d_rdata} !== '0) begin n_bad++; $display("FAIL fetch_d_rvalid: got %b %h want 0", d_rvalid, d_rdata); end
      tick(); m_rvalid = 0; m_rdata = '0;
      @(negedge clk);
      n_cmp++; if ({if_rvalid, m_req} !== 2'b00) begin n_bad++; $display("FAIL fetch_c3: got rv/mreq %b want 00", {if_rvalid, m_req}); end
      tick();
   endtask

   task automatic test_write_stall();
      d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'h55AA; d_be = 4'h3;
      @(negedge clk);
      n_cmp++; if ({d_gnt, if_gnt} !== 2'b10) begin n_bad++; $display("FAIL write_gnt: got %b want 10", {d_gnt, if_gnt}); end
      tick(); d_req = 0; d_we = 0; d_addr = 32'h1234; d_wdata = '1; d_be = 4'hC;
      for (int s = 0; s < 4; s++) begin
         m_gnt = (s == 3);
         @(negedge clk);
         n_cmp++; if ({m_req, m_we, m_addr, m_wdata, m_be} !== {2'b11, 32'h2000, 32'h55AA, 4'h3}) begin n_bad++; $display("FAIL write_req_%0d: got req %b we %b addr %h wd %h be %h", s, m_req, m_we, m_addr, m_wdata, m_be); end
         tick();
      end
      m_gnt = 0;
      @(negedge clk);
      n_cmp++; if ({d_rvalid, m_req} !== 2'b00) begin n_bad++; $display("FAIL write_wait: got rv/mreq %b want 00", {d_rvalid, m_req}); end
      tick(); m_rvalid = 1;
      @(negedge clk);
      n_cmp++; if ({d_rvalid, d_err, if_rvalid} !== 3'b100) begin n_bad++; $display("FAIL write_ack: got %b want 100", {d_rvalid, d_err, if_rvalid}); end
      tick(); idle_inputs();
      tick();
   endtask

   task automatic test_contention();
      do_reset();
      if_req = 1; if_addr = 32'hF00; d_req = 1; d_addr = 32'hD00;
      for (int k = 0; k < 10; k++) begin
         logic exp_f;
         exp_f = ((k % 5) == 4);
         @(negedge clk);
         n_cmp++; if ({if_gnt, d_gnt} !== {exp_f, !exp_f}) begin n_bad++; $display("FAIL contention_%0d: got if/d %b want %b", k, {if_gnt, d_gnt}, {exp_f, !exp_f}); end
         tick(); m_gnt = 1;
         tick(); m_gnt = 0; m_rvalid = 1; m_rdata = 32'(k);
         @(negedge clk);
         n_cmp++; if ({if_rvalid, d_rvalid} !== {exp_f, !exp_f}) begin n_bad++; $display("FAIL contention_rsp_%0d: got if/d %b want %b", k, {if_rvalid, d_rvalid}, {exp_f, !exp_f}); end
         tick(); m_rvalid = 0;
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_timeout();
      d_req = 1; d_we = 0; d_addr = 32'h3000;
      tick(); d_req = 0; m_gnt = 1;
      tick(); m_gnt = 0; m_rdata = 32'hA5A5A5A5;
      for (int i = 0; i <= TMO; i++) begin
         @(negedge clk);
         if (i < TMO) begin
            n_cmp++; if (d_rvalid !== 1'b0) begin n_bad++; $display("FAIL timeout_early_%0d: got rvalid %b want 0", i, d_rvalid); end
         end else begin
            n_cmp++; if ({d_rvalid, d_err, d_rdata, if_rvalid} !== {2'b11, 32'h0, 1'b0}) begin n_bad++; $display("FAIL timeout_err: got rv %b err %b data %h ifrv %b want 1 1 0 0", d_rvalid, d_err, d_rdata, if_rvalid); end
         end
         tick();
      end
      @(negedge clk);
      n_cmp++; if ({d_rvalid, m_req} !== 2'b00) begin n_bad++; $display("FAIL timeout_after: got %b want 00", {d_rvalid, m_req}); end
      tick(); idle_inputs();
   endtask

   task automatic test_reset_in_wait();
      do_reset();
      d_req = 1; d_addr = 32'h40;
      tick(); d_req = 0; m_gnt = 1;
      tick(); m_gnt = 0;
      tick(); rst = 1; m_rvalid = 1; m_rdata = 32'h1111;
      @(negedge clk);
      n_cmp++; if ({d_rvalid, if_rvalid, m_req} !== 3'b000) begin n_bad++; $display("FAIL rstwait_rst_cycle: got %b want 000", {d_rvalid, if_rvalid, m_req}); end
      tick(); rst = 0;
      @(negedge clk);
      n_cmp++; if ({d_rvalid, if_rvalid, m_req} !== 3'b000) begin n_bad++; $display("FAIL rstwait_late_rvalid: got %b want 000", {d_rvalid, if_rvalid, m_req}); end
      tick(); m_rvalid = 0; if_req = 1; if_addr = 32'h44;
      @(negedge clk);
      n_cmp++; if ({if_gnt, d_gnt} !== 2'b10) begin n_bad++; $display("FAIL rstwait_next_gnt: got %b want 10", {if_gnt, d_gnt}); end
      tick(); if_req = 0; m_gnt = 1;
      @(negedge clk);
      n_cmp++; if ({m_req, m_addr} !== {1'b1, 32'h44}) begin n_bad++; $display("FAIL rstwait_next_req: got %b %h want 1 44", m_req, m_addr); end
      tick(); m_gnt = 0; m_rvalid = 1; m_rdata = 32'h2222;
      @(negedge clk);
      n_cmp++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h2222}) begin n_bad++; $display("FAIL rstwait_next_rsp: got %b %h want 1 2222", if_rvalid, if_rdata); end
      tick(); idle_inputs();
      tick();
   endtask

   task automatic test_stale_rvalid();
      d_req = 1; d_addr = 32'h50;
      tick(); d_req = 0; m_rvalid = 1; m_rdata = 32'hBAD;
      @(negedge clk);
      n_cmp++; if ({m_req, d_rvalid, if_rvalid} !== 3'b100) begin n_bad++; $display("FAIL stale_req: got %b want 100", {m_req, d_rvalid, if_rvalid}); end
      tick(); m_rvalid = 0; m_gnt = 1;
      @(negedge clk);
      n_cmp++; if (d_rvalid !== 1'b0) begin n_bad++; $display("FAIL stale_gnt_cycle: got %b want 0", d_rvalid); end
      tick(); m_gnt = 0; m_rvalid = 1; m_rdata = 32'h600D;
      @(negedge clk);
      n_cmp++; if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'h600D}) begin n_bad++; $display("FAIL stale_rsp: got %b %b %h want 1 0 600d", d_rvalid, d_err, d_rdata); end
      tick(); idle_inputs();
      tick();
   endtask

   // Random traffic against a transaction-level model: data wins unless the
   // fetch has been passed over MAXD times in a row; responses time out after
   // TMO waiting cycles.
   task automatic test_random();
      int streak;
      logic exp_f, exp_d, own_d, done, exp_err;
      logic exp_we;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_wdata, exp_rd;
      logic [3:0] exp_be;
      logic got_v, got_e, oth_v;
      logic [DW-1:0] got_d, oth_d;
      int gstall, rlat, pick;
      do_reset();
      streak = 0;
      for (int t = 0; t < 80; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            if_req = 0; d_req = 0;
            @(negedge clk);
            n_cmp++; if ({if_gnt, d_gnt} !== 2'b00) begin n_bad++; $display("FAIL rnd_gap_%0d: got %b want 00", t, {if_gnt, d_gnt}); end
            streak = 0;
            tick();
         end
         pick = int'($urandom_range(0, 7));
         if_req = (pick != 1); d_req = (pick != 0);
         if_addr = $urandom; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
         d_wdata = $urandom; d_be = 4'($urandom);
         exp_f = if_req && (!d_req || streak == MAXD);
         exp_d = d_req && !exp_f;
         if (exp_f || !if_req) streak = 0;
         else if (exp_d && streak < MAXD) streak = streak + 1;
         own_d = exp_d;
         exp_we = exp_d ? d_we : 1'b0;
         exp_addr = exp_d ? d_addr : if_addr;
         exp_wdata = d_wdata;
         exp_be = exp_d ? d_be : 4'hF;
         @(negedge clk);
         n_cmp++; if ({if_gnt, d_gnt} !== {exp_f, exp_d}) begin n_bad++; $display("FAIL rnd_gnt_%0d: got if/d %b want %b", t, {if_gnt, d_gnt}, {exp_f, exp_d}); end
         tick();
         if (own_d) d_req = 0; else if_req = 0;
         gstall = int'($urandom_range(0, 2));
         for (int s = 0; s <= gstall; s++) begin
            m_gnt = (s == gstall); m_rvalid = 1'($urandom_range(0, 1)); m_rdata = $urandom;
            @(negedge clk);
            n_cmp++; if ({m_req, m_we, m_addr, m_be} !== {1'b1, exp_we, exp_addr, exp_be}) begin n_bad++; $display("FAIL rnd_mreq_%0d: got req %b we %b addr %h be %h want 1 %b %h %h", t, m_req, m_we, m_addr, m_be, exp_we, exp_addr, exp_be); end
            if (own_d) begin
               n_cmp++; if (m_wdata !== exp_wdata) begin n_bad++; $display("FAIL rnd_wdata_%0d: got %h want %h", t, m_wdata, exp_wdata); end
            end
            n_cmp++; if ({if_gnt, d_gnt, if_rvalid, d_rvalid} !== 4'b0) begin n_bad++; $display("FAIL rnd_req_quiet_%0d: got %b want 0000", t, {if_gnt, d_gnt, if_rvalid, d_rvalid}); end
            tick();
         end
         m_gnt = 0;
         rlat = int'($urandom_range(0, 10));
         done = 0;
         for (int i = 0; i <= TMO && !done; i++) begin
            m_rvalid = (i == rlat); m_rdata = $urandom;
            @(negedge clk);
            done = (i == rlat) || (i == TMO);
            exp_err = done && (i != rlat);
            exp_rd = (done && !exp_err) ? m_rdata : '0;
            got_v = own_d ? d_rvalid : if_rvalid;
            got_e = own_d ? d_err : if_err;
            got_d = own_d ? d_rdata : if_rdata;
            oth_v = own_d ? if_rvalid : d_rvalid;
            oth_d = own_d ? if_rdata : d_rdata;
            n_cmp++; if ({got_v, got_e, got_d} !== {done, exp_err, exp_rd}) begin n_bad++; $display("FAIL rnd_rsp_%0d_%0d: got rv %b err %b data %h want %b %b %h", t, i, got_v, got_e, got_d, done, exp_err, exp_rd); end
            n_cmp++; if ({oth_v, oth_d, if_gnt, d_gnt, m_req} !== '0) begin n_bad++; $display("FAIL rnd_other_%0d_%0d: got rv %b data %h gnt %b%b mreq %b want 0", t, i, oth_v, oth_d, if_gnt, d_gnt, m_req); end
            tick();
         end
         m_rvalid = 0;
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1;
      idle_inputs();
      test_reset();
      test_single_fetch();
      test_write_stall();
      test_contention();
      test_timeout();
      test_reset_in_wait();
      test_stale_rvalid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
